// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline front end: PC-source encodings,
// the bubble instruction, fetch-state encoding and an alignment helper.
package pipe_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned PCSRC_W = 2;

  localparam logic [PCSRC_W-1:0] PCSRC_SEQ = 2'b00;
  localparam logic [PCSRC_W-1:0] PCSRC_BR  = 2'b01;
  localparam logic [PCSRC_W-1:0] PCSRC_JR  = 2'b10;
  localparam logic [PCSRC_W-1:0] PCSRC_J   = 2'b11;

  // sll $0,$0,0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0000;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_HOLD = 1'b1
  } fetch_state_e;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return addr & ~XLEN'(3);
  endfunction

endpackage

// File: rtl/pipe_pc_mux.sv
// Next-PC target selection (sequential, branch, register jump, absolute jump)
// with word alignment applied to the selected target.
module pipe_pc_mux
  import pipe_pkg::*;
(
  input  logic [PCSRC_W-1:0] sel,
  input  logic [XLEN-1:0]    seq,
  input  logic [XLEN-1:0]    bpc,
  input  logic [XLEN-1:0]    rpc,
  input  logic [XLEN-1:0]    jpc,
  output logic [XLEN-1:0]    target
);

  logic [XLEN-1:0] raw;

  always_comb begin
    raw = seq;
    unique case (sel)
      PCSRC_SEQ: raw = seq;
      PCSRC_BR:  raw = bpc;
      PCSRC_JR:  raw = rpc;
      PCSRC_J:   raw = jpc;
      default:   raw = seq;
    endcase
    target = align_word(raw);
  end

endmodule

// File: rtl/pipe_fetch_stage.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ack memory port,
// inserts bubbles during wait states and parks a redirect until the delay slot lands.
module pipe_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ack,
  output logic [31:0] pc,
  output logic [31:0] p4,
  output logic [31:0] inst,
  output logic        wir
);

  import pipe_pkg::*;

  fetch_state_e    state, state_nxt;
  logic [XLEN-1:0] pc_nxt;
  logic [XLEN-1:0] hold_buf, hold_buf_nxt;
  logic            red_valid, red_valid_nxt;
  logic [XLEN-1:0] red_target, red_target_nxt;
  logic [XLEN-1:0] sel_target;
  logic [XLEN-1:0] npc;

  assign p4 = pc + XLEN'(4);

  pipe_pc_mux u_pc_mux (
    .sel    (pcsource),
    .seq    (p4),
    .bpc    (bpc),
    .rpc    (rpc),
    .jpc    (jpc),
    .target (sel_target)
  );

  // A parked redirect outranks whatever ID presents now.
  assign npc = red_valid ? red_target : sel_target;

  assign imem_addr = pc;
  assign imem_req  = clrn && (state == S_REQ);
  assign wir       = clrn && wpcir;

  // Instruction presented to IF/ID; bubbles whenever no word is deliverable.
  always_comb begin
    inst = NOP_INST;
    if (clrn) begin
      unique case (state)
        S_REQ:   if (imem_ack && wpcir) inst = imem_rdata;
        S_HOLD:  if (wpcir) inst = hold_buf;
        default: inst = NOP_INST;
      endcase
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    hold_buf_nxt   = hold_buf;
    red_valid_nxt  = red_valid;
    red_target_nxt = red_target;
    unique case (state)
      S_REQ: begin
        if (imem_ack) begin
          if (wpcir) begin
            pc_nxt        = npc;
            red_valid_nxt = 1'b0;
          end else begin
            hold_buf_nxt = imem_rdata;
            state_nxt    = S_HOLD;
          end
        end else if (wpcir && (pcsource != PCSRC_SEQ) && !red_valid) begin
          // Branch left ID while its delay slot is still in flight.
          red_target_nxt = sel_target;
          red_valid_nxt  = 1'b1;
        end
      end
      S_HOLD: begin
        if (wpcir) begin
          pc_nxt        = npc;
          red_valid_nxt = 1'b0;
          state_nxt     = S_REQ;
        end
      end
      default: state_nxt = S_REQ;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      hold_buf   <= '0;
      red_valid  <= 1'b0;
      red_target <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      hold_buf   <= hold_buf_nxt;
      red_valid  <= red_valid_nxt;
      red_target <= red_target_nxt;
    end
  end

  // A second redirect while one is parked cannot happen with bubble insertion.
  a_no_double_redirect : assert property (@(posedge clk) disable iff (!clrn)
    !(red_valid && wpcir && (pcsource != PCSRC_SEQ)));

  a_pc_aligned : assert property (@(posedge clk) disable iff (!clrn)
    pc[1:0] == 2'b00);

endmodule

// File: tb/tb_pipe_fetch_stage.sv
// Directed bench for pipe_fetch_stage: vector table plus reset sequences.
module tb_pipe_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        clrn;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] pc, p4, inst;
  logic        wir;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic        wpcir;
    logic [1:0]  ps;
    logic [31:0] tgt;
    logic        ack;
    logic [31:0] exp_pc;
    logic [31:0] exp_inst;
    logic        exp_req;
  } vec_t;

  vec_t vecs[$];

  pipe_fetch_stage dut (
    .clk        (clk),
    .clrn       (clrn),
    .wpcir      (wpcir),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .rpc        (rpc),
    .jpc        (jpc),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .pc         (pc),
    .p4         (p4),
    .inst       (inst),
    .wir        (wir)
  );

  always #5 clk = ~clk;

  // Memory contents: a distinct non-zero word per address.
  function automatic logic [31:0] mw(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = mw(imem_addr);

  function automatic vec_t mkv(input logic w, input logic [1:0] ps, input logic [31:0] tgt,
                               input logic ack, input logic [31:0] epc,
                               input logic [31:0] einst, input logic ereq);
    vec_t v;
    v.wpcir = w; v.ps = ps; v.tgt = tgt; v.ack = ack;
    v.exp_pc = epc; v.exp_inst = einst; v.exp_req = ereq;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Unselected targets get decoys so a wrong mux leg shows up.
  task automatic drive(input vec_t v);
    wpcir    = v.wpcir;
    pcsource = v.ps;
    imem_ack = v.ack;
    bpc = (v.ps == 2'b01) ? v.tgt : 32'h0000_0BB0;
    rpc = (v.ps == 2'b10) ? v.tgt : 32'h0000_0CC0;
    jpc = (v.ps == 2'b11) ? v.tgt : 32'h0000_0DD0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(negedge clk);
    clrn = 1'b1;
    drive(v);
    #1;
    n_vec++;
    chk($sformatf("v%0d pc", idx), pc, v.exp_pc);
    chk($sformatf("v%0d p4", idx), p4, v.exp_pc + 32'd4);
    chk($sformatf("v%0d addr", idx), imem_addr, v.exp_pc);
    chk($sformatf("v%0d inst", idx), inst, v.exp_inst);
    chk($sformatf("v%0d wir", idx), 32'(wir), 32'(v.wpcir));
    chk($sformatf("v%0d req", idx), 32'(imem_req), 32'(v.exp_req));
  endtask

  task automatic reset_check(input string name);
    n_vec++;
    chk({name, " pc"}, pc, 32'h0);
    chk({name, " req"}, 32'(imem_req), 32'd0);
    chk({name, " wir"}, 32'(wir), 32'd0);
    chk({name, " inst"}, inst, NOP);
  endtask

  initial begin
    // Zero-wait sequential run, jump with misaligned target, jr to top of memory.
    vecs.push_back(mkv(1, 2'b00, 0,            1, 32'h0000_0000, mw(32'h0000_0000), 1));
    vecs.push_back(mkv(1, 2'b00, 0,            1, 32'h0000_0004, mw(32'h0000_0004), 1));
    vecs.push_back(mkv(1, 2'b11, 32'h2003,     1, 32'h0000_0008, mw(32'h0000_0008), 1));
    vecs.push_back(mkv(1, 2'b10, 32'hFFFF_FFFC,1, 32'h0000_2000, mw(32'h0000_2000), 1));
    vecs.push_back(mkv(1, 2'b00, 0,            1, 32'hFFFF_FFFC, mw(32'hFFFF_FFFC), 1));
    // Branch together with ack: taken immediately.
    vecs.push_back(mkv(1, 2'b01, 32'h40,       1, 32'h0000_0000, mw(32'h0000_0000), 1));
    // Two wait states at 0x40.
    vecs.push_back(mkv(1, 2'b00, 0,            0, 32'h0000_0040, NOP,               1));
    vecs.push_back(mkv(1, 2'b00, 0,            0, 32'h0000_0040, NOP,               1));
    vecs.push_back(mkv(1, 2'b00, 0,            1, 32'h0000_0040, mw(32'h0000_0040), 1));
    vecs.push_back(mkv(1, 2'b11, 32'h10,       1, 32'h0000_0044, mw(32'h0000_0044), 1));
    // Stall on the ack cycle at 0x10, hold, then release.
    vecs.push_back(mkv(0, 2'b00, 0,            1, 32'h0000_0010, NOP,               1));
    vecs.push_back(mkv(0, 2'b00, 0,            0, 32'h0000_0010, NOP,               0));
    vecs.push_back(mkv(1, 2'b00, 0,            0, 32'h0000_0010, mw(32'h0000_0010), 0));
    vecs.push_back(mkv(1, 2'b11, 32'h20,       1, 32'h0000_0014, mw(32'h0000_0014), 1));
    // Delay slot at 0x20 with one wait state; branch parked until ack.
    vecs.push_back(mkv(1, 2'b01, 32'h100,      0, 32'h0000_0020, NOP,               1));
    vecs.push_back(mkv(1, 2'b00, 0,            1, 32'h0000_0020, mw(32'h0000_0020), 1));
    vecs.push_back(mkv(1, 2'b00, 0,            1, 32'h0000_0100, mw(32'h0000_0100), 1));
    vecs.push_back(mkv(1, 2'b11, 32'h30,       1, 32'h0000_0104, mw(32'h0000_0104), 1));
    vecs.push_back(mkv(1, 2'b00, 0,            0, 32'h0000_0030, NOP,               1));

    clrn = 1'b0;
    wpcir = 1'b1; pcsource = 2'b00; imem_ack = 1'b1;
    bpc = 32'h0BB0; rpc = 32'h0CC0; jpc = 32'h0DD0;
    #3;
    reset_check("por");

    foreach (vecs[i]) apply(vecs[i], i);

    // Reset mid-request at 0x30: req drops and pc clears without a clock edge.
    @(negedge clk);
    #1;
    chk("pre-rst req", 32'(imem_req), 32'd1);
    chk("pre-rst pc", pc, 32'h30);
    clrn = 1'b0;
    imem_ack = 1'b1;
    #1;
    reset_check("midrst");

    apply(mkv(1, 2'b00, 0, 1, 32'h0000_0000, mw(32'h0000_0000), 1), 100);
    apply(mkv(1, 2'b00, 0, 1, 32'h0000_0004, mw(32'h0000_0004), 1), 101);
    apply(mkv(1, 2'b00, 0, 1, 32'h0000_0008, mw(32'h0000_0008), 1), 102);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
